// File: rtl/fir_mac_pkg.sv
// Shared definitions for the FIR datapath blocks: default width, divider
// state encoding and saturation constants.
package fir_mac_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor magnitude, keep the difference only if it stays non-negative.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = shifted - {2'b00, dvs_i};
    q_bit_o = ~trial[WIDTH+1];
    rem_o   = trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider with valid/ready on both sides and a
// fixed 9-edge (WIDTH+1) latency from acceptance to out_valid.
module seq_divider
  import fir_mac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output state_e           dbg_state
);

  // Handshake: a transfer happens on any rising edge where valid && ready are
  // both high; valid never depends on ready, and payload is stable while
  // valid is high and ready is low.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] QMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] QMIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q_q, sgn_q_d;
  logic             sgn_r_q, sgn_r_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH:0]   step_rem;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i   (rem_q),
    .bit_i   (dvd_q[WIDTH-1]),
    .dvs_i   (dvs_q),
    .rem_o   (step_rem),
    .q_bit_o (step_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      dvd_q         <= '0;
      dvs_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      cnt_q         <= '0;
      sgn_q_q       <= 1'b0;
      sgn_r_q       <= 1'b0;
      dbz_q         <= 1'b0;
      ovf_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      dvd_q         <= dvd_d;
      dvs_q         <= dvs_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      cnt_q         <= cnt_d;
      sgn_q_q       <= sgn_q_d;
      sgn_r_q       <= sgn_r_d;
      dbz_q         <= dbz_d;
      ovf_q         <= ovf_d;
      out_valid_q   <= out_valid_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    cnt_d         = cnt_q;
    sgn_q_d       = sgn_q_q;
    sgn_r_d       = sgn_r_q;
    dbz_d         = dbz_q;
    ovf_d         = ovf_q;
    out_valid_d   = out_valid_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Unsigned WIDTH-bit magnitudes, so the most-negative value maps cleanly.
          dvd_d   = dividend[WIDTH-1] ? -dividend : dividend;
          dvs_d   = divisor[WIDTH-1]  ? -divisor  : divisor;
          sgn_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sgn_r_d = dividend[WIDTH-1];
          dbz_d   = (divisor == '0);
          ovf_d   = (dividend == QMIN) && (divisor == '1);
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_bit};
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = SIGN;
      end
      SIGN: begin
        div_by_zero_d = dbz_q;
        overflow_d    = ovf_q;
        if (dbz_q) begin
          // With a zero divisor every trial succeeds, so the partial
          // remainder ends up holding the dividend magnitude unchanged.
          quotient_d  = sgn_r_q ? QMIN : QMAX;
          remainder_d = sgn_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        end else if (ovf_q) begin
          quotient_d  = QMAX;
          remainder_d = '0;
        end else begin
          quotient_d  = sgn_q_q ? -quo_q : quo_q;
          remainder_d = sgn_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle signed restoring divider: the inverse of the multiply/accumulate path in the FIR datapath.
- Used for gain normalisation and coefficient scaling, where an accumulated result is divided back down.
- Operands enter over a valid/ready handshake; one quotient bit is resolved per clock; results leave over a valid/ready handshake.
- Signed two's-complement operands, same width as the adder datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (signed two's complement).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  dividend/divisor present
- in_ready  output  1  block can accept operands
- dividend  input  WIDTH  signed numerator
- divisor  input  WIDTH  signed denominator
- out_valid  output  1  result registers valid
- out_ready  input  1  downstream accepts result
- quotient  output  WIDTH  signed quotient
- remainder  output  WIDTH  signed remainder
- div_by_zero  output  1  divisor was 0 for this result
- overflow  output  1  quotient not representable (most-negative / -1)

Behaviour:
- Reset (synchronous, active-high, has priority over everything):
  - state=IDLE; in_ready=1; out_valid=0.
  - quotient, remainder, div_by_zero, overflow = 0.
- Reset mid-operation aborts the division; no result is ever emitted for the aborted operands.
- States: IDLE, DIV, SIGN, DONE.
- IDLE:
  - in_ready=1.
  - Accept on the edge where in_valid && in_ready (edge E0).
  - Capture |dividend| and |divisor| as WIDTH-bit unsigned values (the magnitude of -128 is 128).
  - Capture sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Capture the div_by_zero and overflow conditions.
  - Clear the WIDTH+1-bit partial remainder and the iteration counter; go to DIV.
- DIV:
  - in_ready=0.
  - Each edge performs one restoring step:
    - shift the partial remainder left, bringing in the next dividend MSB;
    - trial-subtract the divisor magnitude;
    - if the result is non-negative, keep it and the quotient bit is 1; else restore and the quotient bit is 0.
  - Exactly WIDTH iterations (E1..E8 for WIDTH=8); counter reaching WIDTH-1 moves to SIGN.
- SIGN (edge E9):
  - Apply signs: quotient negated if sign_q; remainder negated if sign_r.
  - Division truncates toward zero; the remainder takes the dividend's sign; |remainder| < |divisor|.
  - Register the outputs and flags, set out_valid=1, go to DONE.
- Fixed latency: out_valid first high in the cycle after E9, i.e. 9 edges after acceptance, independent of operand values including the special cases.
- DONE:
  - Outputs and flags held stable while out_valid && !out_ready.
  - On the edge with out_ready=1: out_valid=0, state=IDLE.
  - in_ready rises in the following cycle; no same-cycle accept-on-drain.
  - Outputs keep their last value after out_valid drops.
- in_valid is ignored whenever in_ready=0. Input changes after E0 have no effect.
- Divide by zero (divisor=0), overriding the iteration result:
  - quotient = +(2^(WIDTH-1)-1) if dividend>=0, else -(2^(WIDTH-1));
  - remainder = dividend; div_by_zero=1; overflow=0.
- Overflow (dividend = -2^(WIDTH-1) and divisor = -1):
  - quotient = +(2^(WIDTH-1)-1) (saturated), remainder=0, overflow=1.
- out_ready asserted while out_valid=0 has no effect.

Decomposition:
- Shared package fir_mac_pkg:
  - WIDTH default constant;
  - state enum (IDLE, DIV, SIGN, DONE);
  - SAT_MAX / SAT_MIN constants.
- One natural sub-module: div_step, a combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new partial remainder, quotient bit.
- The FSM, counter and sign fix-up remain in seq_divider.

Test Plan:
- 100 / 7, out_ready=1 → quotient=14, remainder=2, flags 0; out_valid first high exactly 9 edges after acceptance; in_ready low throughout.
- Sign matrix → results as follows:
  - -100/7 → q=-14, r=-2;
  - 100/-7 → q=-14, r=2;
  - -100/-7 → q=14, r=-2;
  - 6/7 → q=0, r=6;
  - -128/1 → q=-128, r=0.
- Divide by zero → same 9-edge latency for each case:
  - 5/0 → q=127, r=5, div_by_zero=1;
  - -5/0 → q=-128, r=-5, div_by_zero=1.
- -128 / -1 → q=127, r=0, overflow=1. Also -128/2 → q=-64, r=0, flags 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, toggling in_valid with new operands → outputs stable and in_ready=0. Raising out_ready → out_valid drops next edge, in_ready=1 the cycle after, and the next operands are processed correctly.
- Assert rst for one cycle at iteration 4 of 50/5 → next cycle in_ready=1, out_valid=0, outputs 0, no result emitted. Then 50/5 → q=10, r=0.
